// File: rtl/bf_stdout_ctrl.sv
// rtl/bf_stdout_ctrl.sv - CPU stdout byte buffer and UART transmit scheduler
//
// Buffers bytes strobed by the CPU into a circular FIFO and feeds them one at
// a time to a byte-wide UART transmitter via a start/busy handshake.
//
// Optional feature macro: BF_STDOUT_CRLF_EN
//   defined   - a buffered 0x0A is transmitted as 0x0D followed by 0x0A
//   undefined - bytes are transmitted verbatim
//
// Parameters:
//   FIFO_DEPTH_LOG2 - log2 of FIFO depth in bytes (2..8)
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   stdout_en  in   one-cycle CPU write strobe
//   stdout     in   [7:0] byte from CPU, sampled with stdout_en
//   cpu_stall  out  CPU must hold off new strobes while high
//   tx_data    out  [7:0] byte presented to UART, held between frames
//   tx_start   out  one-cycle transmit request
//   tx_busy    in   UART busy
//   fifo_level out  [FIFO_DEPTH_LOG2:0] bytes buffered
//   overflow   out  sticky, a strobe arrived while the FIFO was full

module bf_stdout_ctrl #(
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stdout_en,
    input  logic [7:0]                 stdout,
    output logic                       cpu_stall,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    localparam logic [FIFO_DEPTH_LOG2:0]   LVL_FULL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
    localparam logic [FIFO_DEPTH_LOG2:0]   LVL_NEAR = {1'b0, {FIFO_DEPTH_LOG2{1'b1}}};
    localparam logic [FIFO_DEPTH_LOG2:0]   LVL_ONE  = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = {{(FIFO_DEPTH_LOG2-1){1'b0}}, 1'b1};

    localparam logic [7:0] CHR_LF = 8'h0A;
`ifdef BF_STDOUT_CRLF_EN
    localparam logic [7:0] CHR_CR = 8'h0D;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } tx_state_t;

    tx_state_t state;
    tx_state_t state_nxt;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [7:0]                 head;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic                       load;
    logic [7:0]                 load_val;

`ifdef BF_STDOUT_CRLF_EN
    logic                       pend_lf;
    logic                       plf_set;
    logic                       plf_clr;
`endif

    // Full/empty are judged on the registered level only, so a strobe at
    // full is dropped even if the FSM pops in the same cycle.
    assign fifo_full  = (fifo_level == LVL_FULL);
    assign fifo_empty = (fifo_level == '0);
    assign push       = stdout_en && !fifo_full;
    assign head       = mem[rd_ptr];

    // Stall one entry early: a strobe already in flight when stall rises
    // still finds a free slot.
    assign cpu_stall  = (fifo_level >= LVL_NEAR);

    // Decoded from the state register so it falls immediately on reset.
    assign tx_start   = (state == ST_START);

    // ------------------------------------------------------------------
    // Transmit sequencer: next state and data-load decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        load_val  = head;
`ifdef BF_STDOUT_CRLF_EN
        plf_set   = 1'b0;
        plf_clr   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = ST_START;
`ifdef BF_STDOUT_CRLF_EN
                    // Send CR first; the LF follows from DONE without
                    // touching the FIFO again.
                    if (head == CHR_LF) begin
                        load_val = CHR_CR;
                        plf_set  = 1'b1;
                    end
`endif
                end
            end
            ST_START: begin
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (tx_busy) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!tx_busy) begin
`ifdef BF_STDOUT_CRLF_EN
                    if (pend_lf) begin
                        load      = 1'b1;
                        load_val  = CHR_LF;
                        plf_clr   = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset: contents are qualified by the level counter)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= stdout;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            state <= state_nxt;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            if (push && !pop) begin
                fifo_level <= fifo_level + LVL_ONE;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - LVL_ONE;
            end

            if (stdout_en && fifo_full) begin
                overflow <= 1'b1;
            end

            if (load) begin
                tx_data <= load_val;
            end
        end
    end

`ifdef BF_STDOUT_CRLF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_lf <= 1'b0;
        end else if (plf_set) begin
            pend_lf <= 1'b1;
        end else if (plf_clr) begin
            pend_lf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bf_stdout_ctrl.sv
// tb/tb_bf_stdout_ctrl.sv - scoreboard bench for bf_stdout_ctrl

module tb_bf_stdout_ctrl;

    localparam int L     = 4;
    localparam int DEPTH = 1 << L;

    logic         clk;
    logic         rst_n;
    logic         stdout_en;
    logic [7:0]   stdout;
    logic         cpu_stall;
    logic [7:0]   tx_data;
    logic         tx_start;
    logic         tx_busy;
    logic [L:0]   fifo_level;
    logic         overflow;

    logic         uart_busy;
    logic         busy_hold;
    int           frame_len;
    int           frame_cnt;
    logic [7:0]   held_data;
    logic         prev_start;
    int           n_starts;

    int           total;
    int           bad;

    logic [7:0]   sb [$];

    assign tx_busy = uart_busy | busy_hold;

    bf_stdout_ctrl #(.FIFO_DEPTH_LOG2(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stdout_en  (stdout_en),
        .stdout     (stdout),
        .cpu_stall  (cpu_stall),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // UART model: busy rises half a cycle after the start pulse is seen and
    // stays high for frame_len cycles; each start is matched to the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            uart_busy  = 1'b0;
            frame_cnt  = 0;
            prev_start = 1'b0;
        end else begin
            if (frame_cnt > 0) begin
                check("tx_data_hold", tx_data, held_data);
                frame_cnt--;
                if (frame_cnt == 0) uart_busy = 1'b0;
            end
            if (tx_start) begin
                check("start_width", prev_start, 1'b0);
                if (sb.size() == 0) begin
                    check("unexpected_start", tx_data, 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", tx_data, sb.pop_front());
                end
                held_data = tx_data;
                uart_busy = 1'b1;
                frame_cnt = frame_len;
                n_starts++;
            end
            prev_start = tx_start;
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic strobe(input logic [7:0] b, input bit accept);
        if (accept) begin
`ifdef BF_STDOUT_CRLF_EN
            if (b == 8'h0A) sb.push_back(8'h0D);
`endif
            sb.push_back(b);
        end
        stdout    = b;
        stdout_en = 1'b1;
        @(negedge clk);
        stdout_en = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && fifo_level == 0 && !uart_busy && !tx_start) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", done, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s0;
        total      = 0;
        bad        = 0;
        n_starts   = 0;
        frame_len  = 10;
        busy_hold  = 1'b0;
        uart_busy  = 1'b0;
        frame_cnt  = 0;
        held_data  = 8'h00;
        prev_start = 1'b0;
        stdout_en  = 1'b0;
        stdout     = 8'h00;
        rst_n      = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_level", fifo_level, 0);
        check("rst_stall", cpu_stall, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte latency
        s0 = n_starts;
        strobe(8'h48, 1'b1);
        check("single_level_n1", fifo_level, 1);
        check("single_start_n1", tx_start, 1'b0);
        @(negedge clk);
        check("single_start_n2", tx_start, 1'b1);
        check("single_data_n2", tx_data, 8'h48);
        drain();
        check("single_pulses", n_starts - s0, 1);
        check("single_level_end", fifo_level, 0);

        // Fill and overflow
        busy_hold = 1'b1;
        for (int i = 1; i <= DEPTH - 1; i++) begin
            strobe(8'(i), 1'b1);
            check("fill_level", fifo_level, i);
            check("fill_stall", cpu_stall, (i >= DEPTH - 1));
        end
        strobe(8'(DEPTH), 1'b1);
        check("full_level", fifo_level, DEPTH);
        check("full_overflow", overflow, 1'b0);
        check("full_stall", cpu_stall, 1'b1);
        strobe(8'hEE, 1'b0);
        check("ovf_level", fifo_level, DEPTH);
        check("ovf_flag", overflow, 1'b1);
        repeat (5) @(negedge clk);
        check("ovf_sticky", overflow, 1'b1);
        busy_hold = 1'b0;
        drain();
        check("ovf_after_drain", overflow, 1'b1);
        check("drain_stall", cpu_stall, 1'b0);

        // Concurrent push and pop at level 3
        busy_hold = 1'b1;
        strobe(8'hA1, 1'b1);
        strobe(8'hA2, 1'b1);
        strobe(8'hA3, 1'b1);
        check("cc_level_pre", fifo_level, 3);
        busy_hold = 1'b0;
        strobe(8'hA4, 1'b1);
        check("cc_level_post", fifo_level, 3);
        check("cc_start", tx_start, 1'b1);
        check("cc_data", tx_data, 8'hA1);
        drain();

        // Line feed handling
        s0 = n_starts;
        strobe(8'h41, 1'b1);
        strobe(8'h0A, 1'b1);
        drain();
`ifdef BF_STDOUT_CRLF_EN
        check("crlf_frames", n_starts - s0, 3);
`else
        check("crlf_frames", n_starts - s0, 2);
`endif

        // Reset mid-frame
        frame_len = 30;
        strobe(8'h11, 1'b1);
        for (int i = 0; i < 5; i++) strobe(8'(8'h21 + i), 1'b1);
        check("mid_level", fifo_level, 5);
        check("mid_busy", tx_busy, 1'b1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_start", tx_start, 1'b0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_stall", cpu_stall, 1'b0);
        check("mid_rst_overflow", overflow, 1'b0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        frame_len = 10;
        @(negedge clk);
        s0 = n_starts;
        strobe(8'h5A, 1'b1);
        @(negedge clk);
        check("post_rst_start", tx_start, 1'b1);
        check("post_rst_data", tx_data, 8'h5A);
        drain();
        check("post_rst_pulses", n_starts - s0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
